// File: rtl/wb_arbiter.sv
// Writeback port arbiter: the pipe always owns the RF write port; multi-cycle results wait in a small FIFO.
// Latency: pipe write -> rf_* next cycle; buffered result -> rf_* no earlier than 2 cycles after accept.
// Backpressure: mc_ready drops when the buffer is full (no credit for a same-cycle drain).
//
// Ports:
//   clk, reset (synchronous, active-low)
//   pipe_we/pipe_rd/pipe_data : writeback stage write request (rd 0 means "no write")
//   mc_valid/mc_rd/mc_data    : multi-cycle unit result, accepted when mc_ready=1
//   rf_we/rf_rd/rf_data/rf_src: registered register-file write (rf_src 1 = from buffer)
//   stall_req                 : asks the hazard logic for a writeback bubble (starvation relief)
//   busy                      : buffer non-empty
//
// Optional feature macro WB_ARBITER_STARVE_EN: adds the loss counter, the FORCE state and
// stall_req. Without it stall_req is tied low and the head waits for a free cycle indefinitely.

module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        rf_src,
    output logic        stall_req,
    output logic        busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // An out-of-range configuration never accepts a result, so the mistake
    // shows up immediately as a hung multi-cycle unit instead of silent corruption.
    localparam bit CFG_OK = (DEPTH >= 1) && (DEPTH <= 4) &&
                            (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15);

`ifdef WB_ARBITER_STARVE_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    logic [4:0]       buf_rd   [DEPTH];
    logic [31:0]      buf_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             pipe_use;
    logic             head_vld;
    logic             accept;
    logic             drain;
    logic             last_out;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    state_t           state;
    state_t           state_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A pipe write to x0 is not a write, so it leaves the port free for the buffer.
    assign pipe_use  = pipe_we && (pipe_rd != 5'd0);
    assign head_vld  = (count != '0);
    assign mc_ready  = CFG_OK && reset && (count < DEPTH_C);
    assign accept    = mc_valid && mc_ready;
    assign drain     = head_vld && !pipe_use;
    // The buffer empties at this edge: only entry leaves and nothing refills it.
    assign last_out  = drain && (count == ONE_C) && !accept;
    assign head_rd   = buf_rd[rd_ptr];
    assign head_data = buf_data[rd_ptr];
    assign busy      = head_vld;

    // Storage needs no reset: count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_rd[wr_ptr]   <= mc_rd;
            buf_data[wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (drain) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous accept and drain leaves the occupancy unchanged.
            case ({accept, drain})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register-file write port
    // ------------------------------------------------------------------
    // A drained head with rd 0 is simply discarded: rf_we drops and the
    // address/data/source registers keep their previous values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we   <= 1'b0;
            rf_rd   <= 5'd0;
            rf_data <= 32'd0;
            rf_src  <= 1'b0;
        end else if (pipe_use) begin
            rf_we   <= 1'b1;
            rf_rd   <= pipe_rd;
            rf_data <= pipe_data;
            rf_src  <= 1'b0;
        end else if (drain && (head_rd != 5'd0)) begin
            rf_we   <= 1'b1;
            rf_rd   <= head_rd;
            rf_data <= head_data;
            rf_src  <= 1'b1;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation tracking
    // ------------------------------------------------------------------
`ifdef WB_ARBITER_STARVE_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] loss_cnt;
    logic [3:0] loss_cnt_nxt;

    // While a head exists every cycle is either a drain or a loss to the pipe.
    always_comb begin
        loss_cnt_nxt = loss_cnt;
        if (drain) begin
            loss_cnt_nxt = 4'd0;
        end else if (head_vld && pipe_use && (loss_cnt != 4'hF)) begin
            loss_cnt_nxt = loss_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            loss_cnt <= 4'd0;
        end else begin
            loss_cnt <= loss_cnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (last_out) begin
                    state_nxt = IDLE;
`ifdef WB_ARBITER_STARVE_EN
                end else if (loss_cnt_nxt >= LIMIT_C) begin
                    state_nxt = FORCE;
`endif
                end
            end
`ifdef WB_ARBITER_STARVE_EN
            // The pipe is asked to bubble until the starving head finally drains.
            FORCE: begin
                if (drain) begin
                    state_nxt = last_out ? IDLE : WAIT;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef WB_ARBITER_STARVE_EN
    assign stall_req = (state == FORCE);
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_ARBITER_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        rf_src;
    logic        stall_req;
    logic        busy;

    logic [41:0] obs;
    assign obs = {rf_we, rf_rd, rf_data, rf_src, stall_req, busy, mc_ready};

    int n_cmp;
    int n_err;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .mc_valid  (mc_valid),
        .mc_rd     (mc_rd),
        .mc_data   (mc_data),
        .mc_ready  (mc_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data),
        .rf_src    (rf_src),
        .stall_req (stall_req),
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of pending results plus the write port it feeds
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_loss;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_src;

    task automatic model_edge();
        bit   use_port;
        bit   acc;
        ent_t e;
        if (!reset) begin
            mq.delete();
            m_loss = 0;
            m_we   = 1'b0;
            m_rd   = 5'd0;
            m_data = 32'd0;
            m_src  = 1'b0;
            return;
        end
        use_port = pipe_we && (pipe_rd != 5'd0);
        acc      = mc_valid && (mq.size() < DEPTH);
        if (use_port) begin
            m_we   = 1'b1;
            m_rd   = pipe_rd;
            m_data = pipe_data;
            m_src  = 1'b0;
            if (mq.size() > 0 && m_loss < 15) m_loss++;
        end else if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_loss = 0;
            if (e.rd != 5'd0) begin
                m_we   = 1'b1;
                m_rd   = e.rd;
                m_data = e.data;
                m_src  = 1'b1;
            end else begin
                m_we = 1'b0;
            end
        end else begin
            m_we = 1'b0;
        end
        if (acc) begin
            e.rd   = mc_rd;
            e.data = mc_data;
            mq.push_back(e);
        end
    endtask

    function automatic logic [41:0] exp_vec();
        logic stall;
        stall = STARVE_ON && (m_loss >= STARVE_LIMIT);
        return {m_we, m_rd, m_data, m_src, stall, (mq.size() != 0),
                (reset && (mq.size() < DEPTH))};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset     = 1'b0;
        pipe_we   = 1'b1;
        pipe_rd   = 5'd9;
        pipe_data = $urandom;
        mc_valid  = 1'b1;
        mc_rd     = 5'd3;
        mc_data   = $urandom;
        tick();
        tick();
        n_cmp++;
        if (obs !== 42'd0) begin
            n_err++;
            $display("FAIL reset.outputs: got %h want %h", obs, 42'd0);
        end
        reset    = 1'b1;
        pipe_we  = 1'b0;
        mc_valid = 1'b0;
        tick();
        n_cmp++;
        if ({mc_ready, busy, rf_we, stall_req} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset.release: got %b want %b",
                     {mc_ready, busy, rf_we, stall_req}, 4'b1000);
        end
    endtask

    task automatic test_pipe_write();
        pipe_we   = 1'b1;
        pipe_rd   = 5'd5;
        pipe_data = 32'hA5A5A5A5;
        mc_valid  = 1'b0;
        tick();
        n_cmp++;
        if ({rf_we, rf_rd, rf_data, rf_src} !== {1'b1, 5'd5, 32'hA5A5A5A5, 1'b0}) begin
            n_err++;
            $display("FAIL pipe.write: got %h want %h", {rf_we, rf_rd, rf_data, rf_src},
                     {1'b1, 5'd5, 32'hA5A5A5A5, 1'b0});
        end
        pipe_rd   = 5'd0;
        pipe_data = 32'h0BAD0BAD;
        tick();
        n_cmp++;
        if ({rf_we, rf_rd, rf_data} !== {1'b0, 5'd5, 32'hA5A5A5A5}) begin
            n_err++;
            $display("FAIL pipe.rd0_hold: got %h want %h", {rf_we, rf_rd, rf_data},
                     {1'b0, 5'd5, 32'hA5A5A5A5});
        end
        pipe_we = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL pipe.idle: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_mc_write();
        pipe_we  = 1'b0;
        mc_valid = 1'b1;
        mc_rd    = 5'd7;
        mc_data  = 32'h1234;
        tick();
        mc_valid = 1'b0;
        n_cmp++;
        if ({rf_we, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL mc.accepted: got %b want %b", {rf_we, busy}, 2'b01);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_rd, rf_data, rf_src, busy} !== {1'b1, 5'd7, 32'h1234, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL mc.write: got %h want %h", {rf_we, rf_rd, rf_data, rf_src, busy},
                     {1'b1, 5'd7, 32'h1234, 1'b1, 1'b0});
        end
    endtask

    task automatic test_starve();
        int         mc_seen;
        logic [4:0] first_mc;
        bit         saw_stall;
        mc_seen   = 0;
        first_mc  = 5'd0;
        saw_stall = 1'b0;
        for (int i = 0; i < 14; i++) begin
            pipe_we   = (i < 8);
            pipe_rd   = 5'(10 + i);
            pipe_data = $urandom;
            mc_valid  = (i < 4);
            mc_rd     = 5'(3 + i);
            mc_data   = $urandom;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL starve cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (rf_we && rf_src) begin
                if (mc_seen == 0) first_mc = rf_rd;
                mc_seen++;
            end
            if (stall_req) saw_stall = 1'b1;
        end
        mc_valid = 1'b0;
        n_cmp++;
        if (mc_seen != 2 || first_mc != 5'd3) begin
            n_err++;
            $display("FAIL starve.mc_writes: got %0d first rd %0d want 2 first rd 3",
                     mc_seen, first_mc);
        end
        n_cmp++;
        if (saw_stall !== STARVE_ON) begin
            n_err++;
            $display("FAIL starve.stall_seen: got %b want %b", saw_stall, STARVE_ON);
        end
    endtask

    task automatic test_rd0();
        pipe_we  = 1'b0;
        mc_valid = 1'b1;
        mc_rd    = 5'd0;
        mc_data  = 32'hDEAD;
        tick();
        mc_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rd0.buffered: got %b want 1", busy);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || busy !== 1'b0 || obs !== exp_vec()) begin
            n_err++;
            $display("FAIL rd0.popped: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        pipe_we   = 1'b1;
        pipe_rd   = 5'd2;
        pipe_data = $urandom;
        mc_valid  = 1'b1;
        mc_rd     = 5'd12;
        mc_data   = $urandom;
        tick();
        mc_rd = 5'd13;
        tick();
        mc_valid = 1'b0;
        n_cmp++;
        if ({busy, mc_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_mid.full: got %b want %b", {busy, mc_ready}, 2'b10);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 42'd0) begin
            n_err++;
            $display("FAIL reset_mid.cleared: got %h want %h", obs, 42'd0);
        end
        reset   = 1'b1;
        pipe_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({rf_we, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_mid.release cyc%0d: got %b want 00", i, {rf_we, busy});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got[$];
        pipe_we = 1'b0;
        for (int i = 0; i < 13; i++) begin
            mc_valid = (i < 10);
            mc_rd    = 5'(i + 1);
            mc_data  = $urandom;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (rf_we && rf_src) got.push_back(rf_rd);
        end
        mc_valid = 1'b0;
        n_cmp++;
        if (got.size() != 10) begin
            n_err++;
            $display("FAIL b2b.count: got %0d want 10", got.size());
        end
        for (int k = 0; k < got.size() && k < 10; k++) begin
            n_cmp++;
            if (got[k] !== 5'(k + 1)) begin
                n_err++;
                $display("FAIL b2b.order[%0d]: got %0d want %0d", k, got[k], k + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) != 0);
            pipe_we   = ($urandom_range(0, 3) != 0);
            pipe_rd   = 5'($urandom_range(0, 31));
            pipe_data = $urandom;
            mc_valid  = $urandom_range(0, 1) != 0;
            mc_rd     = 5'($urandom_range(0, 31));
            mc_data   = $urandom;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        reset    = 1'b1;
        pipe_we  = 1'b0;
        mc_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        m_loss    = 0;
        m_we      = 1'b0;
        m_rd      = 5'd0;
        m_data    = 32'd0;
        m_src     = 1'b0;
        reset     = 1'b0;
        pipe_we   = 1'b0;
        pipe_rd   = 5'd0;
        pipe_data = 32'd0;
        mc_valid  = 1'b0;
        mc_rd     = 5'd0;
        mc_data   = 32'd0;

        test_reset();
        test_pipe_write();
        test_mc_write();
        test_starve();
        test_rd0();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 2, entries in the multi-cycle result buffer (1..4).
REQ-002 SHALL have parameter: STARVE_LIMIT, 4, cycles a buffered head may lose arbitration before stall_req is raised (1..15).
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
REQ-005 SHALL have port: pipe_we  input  1  writeback stage requests a register-file write.
REQ-006 SHALL have port: pipe_rd  input  5  writeback destination register.
REQ-007 SHALL have port: pipe_data  input  32  writeback data.
REQ-008 SHALL have port: mc_valid  input  1  multi-cycle unit result valid.
REQ-009 SHALL have port: mc_rd  input  5  multi-cycle result destination.
REQ-010 SHALL have port: mc_data  input  32  multi-cycle result data.
REQ-011 SHALL have port: mc_ready  output  1  buffer can accept a result this cycle.
REQ-012 SHALL have port: rf_we  output  1  registered register-file write enable.
REQ-013 SHALL have port: rf_rd  output  5  registered write address.
REQ-014 SHALL have port: rf_data  output  32  registered write data.
REQ-015 SHALL have port: rf_src  output  1  source of the current write, 0 = pipe, 1 = multi-cycle.
REQ-016 SHALL have port: stall_req  output  1  request to the hazard logic to insert a writeback bubble.
REQ-017 SHALL have port: busy  output  1  buffer non-empty.

Function
REQ-018 SHALL treat the pipe as using the port when pipe_we=1 and pipe_rd!=0.
REQ-019 SHALL accept a result into the buffer tail on posedge when mc_valid=1 and mc_ready=1.
REQ-020 SHALL drive mc_ready = (count < DEPTH) and reset deasserted, with no credit for a same-cycle drain.
REQ-021 SHALL give the pipe absolute priority: a pipe write in cycle N appears on rf_* in cycle N+1 with rf_src=0.
REQ-022 SHALL drain the buffer head in cycle N when the pipe is not using the port, with rf_* valid in cycle N+1, rf_src=1, and the head popped at the same edge.
REQ-023 SHALL give a result accepted in cycle N a minimum latency of 2 cycles to rf_we (earliest drain in N+1), with no bypass.
REQ-024 SHALL pop a head with rd=0 in a free cycle while driving rf_we=0.
REQ-025 SHALL hold rf_we=0 in any cycle with neither a pipe write nor a drain; rf_rd/rf_data then hold their last values.
REQ-026 SHALL write in FIFO order and perform no rd comparison between pipe and buffer; write ordering is guaranteed by the hazard logic.
REQ-027 SHALL implement states IDLE (empty), WAIT (non-empty, head losing), FORCE (stall_req=1).
REQ-028 SHALL transition IDLE->WAIT on accept, WAIT->IDLE when the last entry drains without a new accept, WAIT->FORCE when the loss counter reaches STARVE_LIMIT, and FORCE->WAIT/IDLE on the next head drain.
REQ-029 SHALL increment a 4-bit loss counter each cycle the head exists and the pipe uses the port, clear it on every drain, and saturate it at 15.
REQ-030 SHALL keep pointers in modulo-DEPTH wrap-around and keep count within 0..DEPTH under simultaneous accept+drain (net count unchanged).

Reset
REQ-031 SHALL, while reset=0 at posedge, empty the buffer, clear the counter, enter IDLE, and drive rf_we=0, rf_rd=0, rf_data=0, rf_src=0, stall_req=0, busy=0, mc_ready=0.
REQ-032 SHALL discard buffered results when reset is asserted mid-operation, with no write issued on release.

Configuration
REQ-033 SHALL, with macro WB_ARBITER_STARVE_EN defined, implement the loss counter, the FORCE state and stall_req per REQ-027..029.
REQ-034 SHALL, without WB_ARBITER_STARVE_EN, omit the counter and FORCE, tie stall_req=0, and leave the head waiting indefinitely for a free cycle.

Verification
REQ-035 SHALL cover: pipe_we=1, rd=5, data=0xA5A5A5A5 -> next cycle rf_we=1, rf_rd=5, rf_src=0.
REQ-036 SHALL cover: mc_valid with rd=7, data=0x1234, pipe idle -> rf_we=1, rf_rd=7, rf_src=1 two cycles after accept, busy=0 afterwards.
REQ-037 SHALL cover: two mc results plus a continuous pipe write -> mc_ready=0 while count=2, no mc write, and (STARVE_EN) stall_req=1 after 4 losses, head written in the first pipe-free cycle, then stall_req=0.
REQ-038 SHALL cover: a head with rd=0 in a free cycle -> popped, rf_we=0, busy falls.
REQ-039 SHALL cover: reset=0 asserted with 2 entries buffered -> all outputs 0 next cycle and no mc write after release.
REQ-040 SHALL cover: DEPTH=2 with accept and drain every cycle for 10 results -> in-order rf_rd sequence and no drop or duplicate across pointer wrap.
